// File: rtl/temp_buf_pkg.sv
// Shared definitions for the banked FIFO: lane mode encodings and the lane-unpack helper.
// The helper works on a fixed maximum lane width so one function serves every CW setting.
package temp_buf_pkg;

  typedef enum logic {
    MODE_NARROW = 1'b0,
    MODE_WIDE   = 1'b1
  } mode_e;

  localparam int LANE_MAX = 64;

  // Extract the hi or lo lane of a stored word; narrow lanes come back zero-extended by one bit.
  function automatic logic [LANE_MAX-1:0] unpack_lane(
    input logic [2*LANE_MAX-1:0] word,
    input mode_e                 mode,
    input logic                  hi,
    input int                    cw
  );
    int                    fw;
    logic [2*LANE_MAX-1:0] sh;
    logic [LANE_MAX-1:0]   mask;
    fw   = (mode == MODE_WIDE) ? cw : cw - 1;
    sh   = hi ? (word >> fw) : word;
    mask = {LANE_MAX{1'b1}} >> (LANE_MAX - fw);
    return sh[LANE_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/temp_bank_fifo_bank.sv
// One bank: circular storage with wrap-bit pointers; full/empty decoded from the registered pointers.
module temp_bank_fifo_bank #(
  parameter int DEPTH = 16,
  parameter int EW    = 51
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Storage needs no reset; contents are only observed behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/temp_bank_fifo.sv
// NBANK parallel FIFOs written one bank at a time and read as a set; popped sets are
// unpacked by stored mode into registered lanes, with sticky overflow/underflow flags.
module temp_bank_fifo
  import temp_buf_pkg::*;
#(
  parameter int NBANK = 2,
  parameter int DEPTH = 16,
  parameter int CW    = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(NBANK)-1:0]   wr_bank,
  input  logic                       wr_mode,
  input  logic [2*CW-1:0]            din,
  input  logic                       rd_en,
  input  logic                       flush,
  output logic [2*NBANK*CW-1:0]      dout,
  output logic                       dout_valid,
  output logic                       dout_mode,
  output logic [NBANK-1:0]           full,
  output logic [NBANK-1:0]           empty,
  output logic                       err_ovf,
  output logic                       err_udf
);

  localparam int BW = $clog2(NBANK);
  localparam int EW = 2*CW + 1;
  localparam int WW = 2*LANE_MAX;

  logic [EW-1:0]          head [NBANK];
  logic [EW-1:0]          wdata;
  logic [NBANK-1:0]       push;
  logic                   rd_ok;
  logic                   wr_drop;
  logic                   mode_mismatch;
  logic [2*NBANK*CW-1:0]  lanes;

  // Handshake: rd_en is a request with no ready; it is honoured only when every bank is
  // non-empty at the edge (no bypass from a same-cycle write), and the result shows as
  // dout_valid one cycle later. A write into a full bank succeeds only if that read is honoured.
  assign wdata   = {wr_mode, din};
  assign rd_ok   = rd_en && (empty == '0) && !flush;
  assign wr_drop = wr_en && full[wr_bank] && !rd_ok && !flush;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign push[b] = wr_en && !flush && (wr_bank == BW'(b)) && (!full[b] || rd_ok);

    temp_bank_fifo_bank #(
      .DEPTH (DEPTH),
      .EW    (EW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .push  (push[b]),
      .pop   (rd_ok),
      .clear (flush),
      .wdata (wdata),
      .rdata (head[b]),
      .full  (full[b]),
      .empty (empty[b])
    );
  end

  always_comb begin
    lanes         = '0;
    mode_mismatch = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      lanes[b*CW +: CW] = CW'(unpack_lane(WW'(head[b][2*CW-1:0]),
                                          mode_e'(head[b][EW-1]), 1'b1, CW));
      lanes[(NBANK+b)*CW +: CW] = CW'(unpack_lane(WW'(head[b][2*CW-1:0]),
                                                  mode_e'(head[b][EW-1]), 1'b0, CW));
      if (head[b][EW-1] != head[0][EW-1]) mode_mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_mode  <= 1'b0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else if (flush) begin
      dout_valid <= 1'b0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      if (rd_ok) begin
        dout      <= lanes;
        dout_mode <= head[0][EW-1];
      end
      if (wr_drop) err_ovf <= 1'b1;
      // Refused read, or a popped set whose banks disagree on packing.
      if ((rd_en && !rd_ok) || (rd_ok && mode_mismatch)) err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_temp_bank_fifo.sv
// Bench for temp_bank_fifo: directed scenarios then random traffic, checked against
// per-bank queue model that applies the packing rules directly.
module tb_temp_bank_fifo;

  localparam int NBANK = 2;
  localparam int DEPTH = 16;
  localparam int CW    = 25;
  localparam int NW    = CW - 1;
  localparam int BW    = $clog2(NBANK);
  localparam int DW    = 2*NBANK*CW;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [BW-1:0]     wr_bank;
  logic              wr_mode;
  logic [2*CW-1:0]   din;
  logic              rd_en;
  logic              flush;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              dout_mode;
  logic [NBANK-1:0]  full;
  logic [NBANK-1:0]  empty;
  logic              err_ovf;
  logic              err_udf;

  temp_bank_fifo #(
    .NBANK (NBANK),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_mode    (wr_mode),
    .din        (din),
    .rd_en      (rd_en),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_mode  (dout_mode),
    .full       (full),
    .empty      (empty),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: one expected queue per bank of {mode, word}
  logic [2*CW:0] exp_q [NBANK][$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_mode;
  logic          exp_ovf;
  logic          exp_udf;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [CW-1:0] lane_of(input logic [2*CW:0] e, input logic hi);
    if (e[2*CW]) return hi ? e[2*CW-1:CW] : e[CW-1:0];
    return hi ? {1'b0, e[2*NW-1:NW]} : {1'b0, e[NW-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [NBANK-1:0] ef;
    logic [NBANK-1:0] ff;
    for (int b = 0; b < NBANK; b++) begin
      ef[b] = (exp_q[b].size() == 0);
      ff[b] = (exp_q[b].size() == DEPTH);
    end
    chk({where, ".valid"}, 128'(dout_valid), 128'(exp_valid));
    chk({where, ".mode"},  128'(dout_mode),  128'(exp_mode));
    chk({where, ".ovf"},   128'(err_ovf),    128'(exp_ovf));
    chk({where, ".udf"},   128'(err_udf),    128'(exp_udf));
    chk({where, ".full"},  128'(full),       128'(ff));
    chk({where, ".empty"}, 128'(empty),      128'(ef));
    chk({where, ".dout"},  128'(dout),       128'(exp_dout));
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBANK; b++) exp_q[b].delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_mode  = 1'b0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic cycle(input string tag, input logic we, input int wb, input logic wm,
                       input logic [2*CW-1:0] d, input logic re, input logic fl);
    logic          any_empty;
    logic          rd_ok;
    logic [2*CW:0] h;
    wr_en   = we;
    wr_bank = wb[BW-1:0];
    wr_mode = wm;
    din     = d;
    rd_en   = re;
    flush   = fl;
    any_empty = 1'b0;
    for (int b = 0; b < NBANK; b++) if (exp_q[b].size() == 0) any_empty = 1'b1;
    rd_ok = re && !any_empty && !fl;
    if (fl) begin
      for (int b = 0; b < NBANK; b++) exp_q[b].delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      exp_valid = rd_ok;
      if (re && !rd_ok) exp_udf = 1'b1;
      if (rd_ok) begin
        for (int b = 0; b < NBANK; b++) begin
          h = exp_q[b].pop_front();
          exp_dout[b*CW +: CW]         = lane_of(h, 1'b1);
          exp_dout[(NBANK+b)*CW +: CW] = lane_of(h, 1'b0);
          if (b == 0) exp_mode = h[2*CW];
          else if (h[2*CW] != exp_mode) exp_udf = 1'b1;
        end
      end
      if (we) begin
        if (exp_q[wb].size() < DEPTH) exp_q[wb].push_back({wm, d});
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [CW-1:0] hv;
    logic [CW-1:0] lv;
    logic [63:0]   r64;
    rst = 1'b0;
    wr_en = 1'b0; wr_bank = '0; wr_mode = 1'b0; din = '0; rd_en = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // narrow round trip
    cycle("nar_w0", 1'b1, 0, 1'b0, {2'b00, 24'h123456, 24'h0ABCDE}, 1'b0, 1'b0);
    cycle("nar_w1", 1'b1, 1, 1'b0, {2'b00, 24'h7FFFFF, 24'h000001}, 1'b0, 1'b0);
    cycle("nar_rd", 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    chk("nar_lane0", 128'(dout[0*CW +: CW]), 128'(25'h0123456));
    chk("nar_lane1", 128'(dout[1*CW +: CW]), 128'(25'h07FFFFF));
    chk("nar_lane2", 128'(dout[2*CW +: CW]), 128'(25'h00ABCDE));
    chk("nar_lane3", 128'(dout[3*CW +: CW]), 128'(25'h0000001));
    chk("nar_mode",  128'(dout_mode),        128'(1'b0));

    // wide traffic wrapping the pointers, reads lagging writes by three sets
    for (int i = 0; i < 40; i++) begin
      hv = 25'h1FFFFFF - CW'(i);
      lv = 25'h1000000 + CW'(i);
      cycle("wide_w0", 1'b1, 0, 1'b1, {hv, lv}, 1'b0, 1'b0);
      cycle("wide_w1", 1'b1, 1, 1'b1, {lv, hv}, (i >= 3), 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle("wide_drain", 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);
    chk("wide_ovf", 128'(err_ovf), 128'(1'b0));
    chk("wide_udf", 128'(err_udf), 128'(1'b0));

    // overflow of bank 0
    cycle("ovf_flush", 1'b0, 0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      r64 = {$urandom(), $urandom()};
      cycle("ovf_w", 1'b1, 0, 1'b1, r64[2*CW-1:0], 1'b0, 1'b0);
      if (i == 15) chk("ovf_full16", 128'(full[0]), 128'(1'b1));
    end
    chk("ovf_flag",   128'(err_ovf),  128'(1'b1));
    chk("ovf_b1_emp", 128'(empty[1]), 128'(1'b1));

    // underflow with a same-cycle write into the empty bank
    cycle("udf_flush", 1'b0, 0, 1'b0, '0, 1'b0, 1'b1);
    cycle("udf_w0", 1'b1, 0, 1'b0, 50'h0_1234_5678_9ABC, 1'b0, 1'b0);
    cycle("udf_rd", 1'b1, 1, 1'b0, 50'h0_0FED_CBA9_8765, 1'b1, 1'b0);
    chk("udf_valid",  128'(dout_valid), 128'(1'b0));
    chk("udf_flag",   128'(err_udf),    128'(1'b1));
    chk("udf_b0_emp", 128'(empty[0]),   128'(1'b0));
    cycle("udf_rd2", 1'b0, 0, 1'b0, '0, 1'b1, 1'b0);

    // flush beats simultaneous read and write
    cycle("fl_w0", 1'b1, 0, 1'b1, 50'h3_0000_0000_0001, 1'b0, 1'b0);
    cycle("fl_w1", 1'b1, 1, 1'b1, 50'h3_0000_0000_0002, 1'b0, 1'b0);
    cycle("fl_all", 1'b1, 0, 1'b1, 50'h1_1111_1111_1111, 1'b1, 1'b1);
    chk("fl_empty", 128'(empty), 128'({NBANK{1'b1}}));
    chk("fl_flags", 128'({err_ovf, err_udf}), 128'(2'b00));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r64 = {$urandom(), $urandom()};
      cycle("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, NBANK-1)),
            1'($urandom_range(0, 1)), r64[2*CW-1:0],
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 63) == 0));
    end

    // reset asserted while a read is in flight
    cycle("rst_w0", 1'b1, 0, 1'b1, 50'h2_AAAA_5555_AAAA, 1'b0, 1'b0);
    cycle("rst_w1", 1'b1, 1, 1'b1, 50'h2_AAAA_5555_AAAA, 1'b0, 1'b0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    chk("rst_valid", 128'(dout_valid), 128'(1'b0));
    chk("rst_empty", 128'(empty),      128'({NBANK{1'b1}}));
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst   = 1'b1;
    rd_en = 1'b0;
    cycle("rst_after_w", 1'b1, 1, 1'b0, 50'h0_0000_00FF_FFFF, 1'b0, 1'b0);
    idle("rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_bank_fifo.md
TEMP_BANK_FIFO -- requirements
Module: temp_bank_fifo

Interface
REQ-001 SHALL have parameter NBANK, default 2, number of banks (power of two, 2..8).
REQ-002 SHALL have parameter DEPTH, default 16, entries per bank (power of two, 4..256).
REQ-003 SHALL have parameter CW, default 25, wide-mode lane width; narrow lane width NW = CW-1.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1, write request.
REQ-007 SHALL have port wr_bank, input, log2(NBANK), target bank of the write.
REQ-008 SHALL have port wr_mode, input, 1, packing of din: 0 = narrow (two NW lanes), 1 = wide (two CW lanes).
REQ-009 SHALL have port din, input, 2*CW, write word; narrow uses din[2*NW-1:0] with hi lane at din[2*NW-1:NW] and lo lane at din[NW-1:0]; wide uses hi lane at din[2*CW-1:CW] and lo lane at din[CW-1:0].
REQ-010 SHALL have port rd_en, input, 1, pop one entry from every bank at once.
REQ-011 SHALL have port flush, input, 1, synchronous clear of all banks and error flags.
REQ-012 SHALL have port dout, output, 2*NBANK*CW, lanes; lane k occupies dout[k*CW +: CW]; lane k (k<NBANK) = bank k hi, lane NBANK+k = bank k lo.
REQ-013 SHALL have port dout_valid, output, 1, dout holds a popped set.
REQ-014 SHALL have port dout_mode, output, 1, stored mode of the popped set.
REQ-015 SHALL have port full, output, NBANK, per-bank full.
REQ-016 SHALL have port empty, output, NBANK, per-bank empty.
REQ-017 SHALL have port err_ovf, output, 1, sticky: a write was dropped.
REQ-018 SHALL have port err_udf, output, 1, sticky: a read was refused.

Function
REQ-019 SHALL keep each bank as a circular FIFO of DEPTH entries; each entry stores (2*CW data bits, 1 mode bit); pointers wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.
REQ-020 SHALL accept a write when wr_en=1 and the bank is not full, or when it is full and the same-cycle read is accepted.
REQ-021 SHALL drop a write to a full bank with no accepted same-cycle read, leave that bank unchanged and set err_ovf the next cycle.
REQ-022 SHALL accept rd_en only when all banks are non-empty; on acceptance every bank pops exactly one entry.
REQ-023 SHALL refuse rd_en when any bank is empty: no bank pops, dout_valid=0 next cycle, err_udf set.
REQ-024 SHALL NOT bypass: a write into an empty bank in the same cycle as rd_en does not satisfy that read.
REQ-025 SHALL register dout with 1-cycle latency; dout_valid=1 exactly the cycle after an accepted read, else 0; dout holds its last value when dout_valid=0.
REQ-026 SHALL unpack by each entry's stored mode: narrow -> lane = {1'b0, NW-bit field}; wide -> full CW field; dout_mode is taken from bank 0's entry.
REQ-027 SHALL flag a mode mismatch across banks on a popped set by setting err_udf.
REQ-028 SHALL give flush priority over wr_en and rd_en in the same cycle: all pointers zeroed, err flags cleared, dout_valid=0 next cycle, dout unchanged.
REQ-029 SHALL update full/empty combinationally from registered pointers, reflecting all writes and reads of the previous cycle.

Reset
REQ-030 SHALL, while rst=0, asynchronously force all pointers to 0, empty all-ones, full all-zeros, dout zero, dout_valid 0, dout_mode 0, err_ovf 0 and err_udf 0; storage contents are undefined.
REQ-031 SHALL discard any in-flight read when rst asserts mid-operation; first accepted write is possible on the first clock edge after release.

Structure
REQ-032 SHALL place mode encodings (NARROW=0, WIDE=1) and the lane-unpack function in shared package temp_buf_pkg.
REQ-033 SHALL instance sub-module temp_bank_fifo_bank (one bank: storage, pointers, full/empty) NBANK times via generate; the top holds arbitration, unpack, output register and error flags.

Verification
REQ-034 SHALL cover narrow round trip: write bank0 din hi=0x123456, lo=0x0ABCDE; write bank1 hi=0x7FFFFF, lo=0x000001; rd_en -> next cycle dout_valid=1, lanes 0..3 = 0x0123456, 0x07FFFFF, 0x00ABCDE, 0x0000001, dout_mode=0.
REQ-035 SHALL cover wide with wrap: 40 write pairs of wide data 0x1FFFFFF/0x1000000 interleaved with reads (DEPTH=16) -> all 40 sets return in order; err flags stay 0.
REQ-036 SHALL cover overflow: 17 writes to bank0 with no read -> full[0]=1 after 16, 17th dropped, err_ovf=1; bank1 untouched.
REQ-037 SHALL cover underflow and no-bypass: bank1 empty, bank0 holds 1 entry, rd_en together with a write to bank1 -> dout_valid=0, err_udf=1, bank0 still holds 1 entry.
REQ-038 SHALL cover flush and reset: flush with rd_en and wr_en high -> all empty, flags 0; rst pulsed low mid-read -> dout_valid=0, empty all-ones.
